jk_mod_counter: RTL

Synchronous modulo-MOD up/down counter whose state is held in a bank of JK flip-flops. The block computes the next count, derives the minimal J/K excitation for each bit, and drives one JK flip-flop per bit. It is the excitation stage that sits directly upstream of the JK storage element, packaged with that storage. Typical use is a BCD digit (MOD=10) in cascaded counter chains, with `tc` driving the next digit's `en`.

---
 rtl/jk_pkg.sv | 21 ++
 rtl/jk_mod_counter_if.sv | 25 ++
 rtl/jk_ff_sync.sv | 29 ++
 rtl/jk_mod_counter.sv | 85 ++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared JK flip-flop command encoding and the minimal-excitation helper.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_cmd_e;

    // Minimal {J,K} to move one bit from cur to nxt; toggle is never needed.
    function automatic jk_cmd_e jk_excite(input logic cur, input logic nxt);
        jk_cmd_e cmd;
        cmd = JK_HOLD;
        if (cur != nxt) begin
            cmd = nxt ? JK_SET : JK_RESET;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control and observation bundle for the modulo JK counter.
interface jk_mod_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qnot;
    logic             tc;
    logic             load_err;
    logic [WIDTH-1:0] j_exc;
    logic [WIDTH-1:0] k_exc;

    modport master (
        output en, up, load, d,
        input  q, qnot, tc, load_err, j_exc, k_exc
    );

    modport slave (
        input  en, up, load, d,
        output q, qnot, tc, load_err, j_exc, k_exc
    );
endinterface

// File: rtl/jk_ff_sync.sv
// Single JK flip-flop with synchronous active-low reset overriding J/K.
module jk_ff_sync
    import jk_pkg::*;
(
    input  logic clk,
    input  logic reset_sync,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Qnot
);

    always_ff @(posedge clk) begin
        if (!reset_sync) begin
            Q <= 1'b0;
        end else begin
            case ({J, K})
                JK_HOLD:   Q <= Q;
                JK_RESET:  Q <= 1'b0;
                JK_SET:    Q <= 1'b1;
                JK_TOGGLE: Q <= ~Q;
                default:   Q <= Q;
            endcase
        end
    end

    assign Qnot = ~Q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter: next-state mux and JK excitation feeding a JK flip-flop bank.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input  logic             clk,
    input  logic             reset_sync,
    jk_mod_counter_if.slave  bus
);

    // One spare bit so q+1 and the range compare never overflow.
    localparam int unsigned AW = WIDTH + 1;
    localparam logic [AW-1:0] MOD_W  = AW'(MOD);
    localparam logic [AW-1:0] LAST_W = AW'(MOD - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qnot;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j_c;
    logic [WIDTH-1:0] k_c;
    logic [AW-1:0]    q_ext;
    logic [AW-1:0]    d_ext;
    logic             load_ok;
    logic             load_bad;
    logic             load_err;

    assign q_ext    = {1'b0, q};
    assign d_ext    = {1'b0, bus.d};
    assign load_ok  = bus.load & (d_ext < MOD_W);
    assign load_bad = bus.load & ~(d_ext < MOD_W);

    // Non-reset next state; reset is applied inside each flip-flop.
    always_comb begin
        nxt = q;
        if (load_ok) begin
            nxt = bus.d;
        end else if (load_bad) begin
            nxt = q;
        end else if (bus.en) begin
            if (bus.up) begin
                nxt = (q_ext >= LAST_W) ? '0 : WIDTH'(q_ext + AW'(1));
            end else begin
                nxt = (q_ext == '0) ? WIDTH'(LAST_W) : WIDTH'(q_ext - AW'(1));
            end
        end
    end

    always_comb begin
        j_c = '0;
        k_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            {j_c[i], k_c[i]} = jk_excite(q[i], nxt[i]);
        end
    end

    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_ff
        jk_ff_sync u_ff (
            .clk        (clk),
            .reset_sync (reset_sync),
            .J          (j_c[gi]),
            .K          (k_c[gi]),
            .Q          (q[gi]),
            .Qnot       (qnot[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_sync) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load_bad;
        end
    end

    assign bus.q        = q;
    assign bus.qnot     = qnot;
    assign bus.j_exc    = j_c;
    assign bus.k_exc    = k_c;
    assign bus.load_err = load_err;
    assign bus.tc       = bus.en & ~bus.load &
                          ((bus.up & (q_ext == LAST_W)) | (~bus.up & (q_ext == '0)));

endmodule
